// File: rtl/sram_rw_arbiter.sv
// Round-robin write/read arbiter for one single-port RW0 SRAM with a one-entry read response buffer.
// Define SRAM_ARB_INIT_CLEAR_EN to zero-fill the whole array before init_done rises.
module sram_rw_arbiter #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  typedef enum logic [1:0] {START, CLEAR, RUN} state_t;
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t state, state_nxt;
  logic   last_wr, rd_pend, err_pend;
  resp_t  resp_q;
  logic   wr_elig, rd_elig, grant_wr, grant_rd, wr_in_rng, rd_in_rng;

  assign wr_in_rng = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_rng = {1'b0, rd_addr} < DEPTH_X;

  // a read may only start when its response has a guaranteed slot two cycles later
  assign wr_elig  = (state == RUN) && wr_valid;
  assign rd_elig  = (state == RUN) && rd_valid && !rd_pend && (!resp_valid || resp_ready);
  assign grant_wr = wr_elig && (!rd_elig || !last_wr);
  assign grant_rd = rd_elig && !grant_wr;

  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;
  assign init_done = (state == RUN);
  assign resp_data = resp_q.data;
  assign resp_err  = resp_q.err;

`ifdef SRAM_ARB_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clear_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              clear_ptr <= '0;
    else if (state == CLEAR)   clear_ptr <= clear_ptr + 1'b1;
    else                       clear_ptr <= '0;
  end
`endif

  always_comb begin
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state)
`ifdef SRAM_ARB_INIT_CLEAR_EN
      START: state_nxt = CLEAR;
      CLEAR: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = clear_ptr;
        if (clear_ptr == ADDR_W'(DEPTH-1)) state_nxt = RUN;
      end
`else
      START: state_nxt = RUN;
      CLEAR: state_nxt = RUN;
`endif
      RUN: begin
        // out-of-range accesses complete their handshake but never reach the macro
        if (grant_wr && wr_in_rng) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = wr_addr;
          sram_wdata = wr_data;
        end else if (grant_rd && rd_in_rng) begin
          sram_en    = 1'b1;
          sram_addr  = rd_addr;
        end
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= START;
      last_wr    <= 1'b0;
      rd_pend    <= 1'b0;
      err_pend   <= 1'b0;
      resp_valid <= 1'b0;
      resp_q     <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= grant_rd;
      if (grant_wr)      last_wr <= 1'b1;
      else if (grant_rd) last_wr <= 1'b0;
      if (grant_rd) err_pend <= !rd_in_rng;
      // rd_pend and a pending response never overlap, so loading here never clobbers held data
      if (rd_pend) begin
        resp_valid <= 1'b1;
        resp_q     <= err_pend ? resp_t'{err: 1'b1, data: '0} : resp_t'{err: 1'b0, data: sram_rdata};
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural RW0 SRAM, shadow-memory scoreboard of read responses.
module tb_sram_rw_arbiter;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;
  localparam int DW    = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, resp_ready = 1'b1;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, resp_valid, resp_err, init_done, sram_en, sram_wmode;
  logic [DW-1:0] resp_data, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         exp_e;
  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] shadow[DEPTH];
  int            checks = 0;
  int            errors = 0;

  always #5 clock = ~clock;

  sram_rw_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .init_done(init_done), .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // RW0 macro: address registered on the enable edge, data valid the following cycle
  always @(posedge clock) begin
    if (sram_en && int'(sram_addr) < DEPTH) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  // Scoreboard: sample 1 time unit before each rising edge
  always @(negedge clock) begin
    #4;
    if (reset_n) begin
      if (wr_valid && wr_ready && int'(wr_addr) < DEPTH) shadow[wr_addr] = wr_data;
      if (rd_valid && rd_ready) begin
        if (int'(rd_addr) >= DEPTH) exp_q.push_back(resp_t'{err: 1'b1, data: '0});
        else                        exp_q.push_back(resp_t'{err: 1'b0, data: shadow[rd_addr]});
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got err=%b data=%h, no response expected", resp_err, resp_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({resp_err, resp_data} !== exp_e) begin
            errors++;
            $display("FAIL resp_data: got err=%b data=%h, want err=%b data=%h",
                     resp_err, resp_data, exp_e.err, exp_e.data);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    int n = 0;
    @(negedge clock); wr_valid = 1'b1; wr_addr = a; wr_data = d; #1;
    while (!wr_ready && n < 20) begin @(negedge clock); #1; n++; end
    ok = wr_ready;
    @(negedge clock); wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output bit ok);
    int n = 0;
    @(negedge clock); rd_valid = 1'b1; rd_addr = a; #1;
    while (!rd_ready && n < 20) begin @(negedge clock); #1; n++; end
    ok = rd_ready;
    @(negedge clock); rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 12'h001; rd_addr = 12'h002;
        repeat (2) @(negedge clock);
      end else begin
        @(negedge clock); reset_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
        n = 0;
        while (!(sram_en && sram_addr == 12'd100) && n < 500) begin @(negedge clock); #1; n++; end
        checks++;
        if (!(sram_en && sram_wmode && sram_addr == 12'd100) || n != 101) begin
          errors++;
          $display("FAIL clear_ptr_100: got addr=%0d en=%b after %0d cycles, want addr=100 en=1 after 101",
                   sram_addr, sram_en, n);
        end
`else
        repeat (3) @(negedge clock);
`endif
        #2; reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
      end
      #1;
      checks++;
      if ({wr_ready, rd_ready, resp_valid, resp_err, init_done, sram_en} !== 6'b0 || resp_data !== '0) begin
        errors++;
        $display("FAIL reset_vals pass%0d: got wr_rdy=%b rd_rdy=%b rv=%b err=%b init=%b en=%b data=%h, want all 0",
                 pass, wr_ready, rd_ready, resp_valid, resp_err, init_done, sram_en, resp_data);
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_init();
    int            n = 0;
    int            want_n;
    logic          first_en = 1'b0, want_en;
    logic [AW-1:0] first_addr = '0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    want_n = 3073; want_en = 1'b1;
`else
    want_n = 1;    want_en = 1'b0;
`endif
    @(negedge clock); reset_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; #1;
    while (!init_done && n < 5000) begin
      @(negedge clock); #1; n++;
      if (n == 1) begin first_en = sram_en; first_addr = sram_addr; end
    end
    checks++;
    if (n != want_n) begin
      errors++;
      $display("FAIL init_cycles: got %0d, want %0d", n, want_n);
    end
    checks++;
    if (first_en !== want_en || first_addr !== '0) begin
      errors++;
      $display("FAIL init_first_cycle: got en=%b addr=%h, want en=%b addr=0", first_en, first_addr, want_en);
    end
  endtask

  task automatic test_clear_read();
    bit ok;
    do_read(12'hBF0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_read_grant: got no rd_ready, want 1"); end
  endtask

  task automatic test_write_read();
    bit ok_w, ok_r;
    do_write(12'h005, 64'hDEADBEEF_CAFEF00D, ok_w);
    do_read(12'h005, ok_r);
    #1;
    checks++;
    if (!ok_w || !ok_r || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency_n1: got w=%b r=%b resp_valid=%b, want 1 1 0", ok_w, ok_r, resp_valid);
    end
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL rd_latency_n2: got rv=%b data=%h, want 1 deadbeefcafef00d", resp_valid, resp_data);
    end
  endtask

  task automatic test_alternate();
    logic [11:0] seq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      wr_valid = 1'b1; wr_addr = 12'h030; wr_data = 64'h1111_2222_3333_0000 | 64'(i);
      rd_valid = 1'b1; rd_addr = 12'h020;
      #1; seq = {seq[9:0], wr_ready, rd_ready};
    end
    @(negedge clock); wr_valid = 1'b0; rd_valid = 1'b0;
    checks++;
    if (seq !== 12'b10_01_10_01_10_01) begin
      errors++;
      $display("FAIL alternate_grants: got %b, want 100110011001", seq);
    end
  endtask

  task automatic test_out_of_range();
    repeat (3) @(negedge clock);
    rd_valid = 1'b1; rd_addr = 12'hC00; #1;
    checks++;
    if (rd_ready !== 1'b1 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_read_grant: got rd_ready=%b sram_en=%b, want 1 0", rd_ready, sram_en);
    end
    @(negedge clock); rd_valid = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0) begin
      errors++;
      $display("FAIL oor_read_resp: got rv=%b err=%b data=%h, want 1 1 0", resp_valid, resp_err, resp_data);
    end
    @(negedge clock); wr_valid = 1'b1; wr_addr = 12'hFFF; wr_data = 64'h0BAD; #1;
    checks++;
    if (wr_ready !== 1'b1 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got wr_ready=%b sram_en=%b, want 1 0", wr_ready, sram_en);
    end
    @(negedge clock); wr_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    do_write(12'h007, 64'hAAAA_0000_0000_0007, ok);
    resp_ready = 1'b0;
    @(negedge clock); rd_valid = 1'b1; rd_addr = 12'h007; #1;
    checks++;
    if (rd_ready !== 1'b1 || !ok) begin
      errors++; $display("FAIL bp_read_grant: got rd_ready=%b wr_ok=%b, want 1 1", rd_ready, ok);
    end
    @(negedge clock); rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 12'h007; wr_data = 64'hBBBB_0000_0000_0007; #1;
    checks++;
    if (wr_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b1) begin
      errors++; $display("FAIL bp_write_n1: got wr_ready=%b en=%b wmode=%b, want 1 1 1", wr_ready, sram_en, sram_wmode);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      rd_valid = 1'b1; rd_addr = 12'h008;
      wr_valid = 1'b1; wr_addr = 12'h010 + 12'(i); wr_data = 64'hC0C0_0000_0000_0000 | 64'(i);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 64'hAAAA_0000_0000_0007 || rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got rv=%b data=%h rd_rdy=%b wr_rdy=%b, want 1 aaaa000000000007 0 1",
                 i, resp_valid, resp_data, rd_ready, wr_ready);
      end
    end
    @(negedge clock); rd_valid = 1'b0; wr_valid = 1'b0; resp_ready = 1'b1;
    do_read(12'h007, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_reread_grant: got no rd_ready, want 1"); end
  endtask

  task automatic test_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
`ifdef SRAM_ARB_INIT_CLEAR_EN
      shadow[i] = '0;
`else
      shadow[i] = mem[i];
`endif
    end
    test_reset();
    test_init();
    test_clear_read();
    test_write_read();
    test_alternate();
    test_out_of_range();
    test_backpressure();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
